// File: rtl/uart_host_cmd_pkg.sv
// Shared constants, error codes and state encodings for the UART host command initiator.
package uart_host_cmd_pkg;

   localparam logic [7:0] SYNC_CMD   = 8'hA5;
   localparam logic [7:0] SYNC_RSP   = 8'h5A;
   localparam logic [7:0] CMD_STREAM = 8'h04;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_CHK = 2'b01;
   localparam logic [1:0] ERR_TMO = 2'b10;
   localparam logic [1:0] ERR_MIS = 2'b11;

   // Host-level sequencing; H_RX covers every RX_* state owned by the parser.
   typedef enum logic [2:0] {
      H_IDLE,
      H_TX_LOAD,
      H_TX_GAP,
      H_TX_WAIT,
      H_RX,
      H_DONE
   } host_state_t;

   typedef enum logic [2:0] {
      RX_HDR,
      RX_CMD,
      RX_LEN_H,
      RX_LEN_L,
      RX_D_H,
      RX_D_L,
      RX_CHK
   } rx_state_t;

   // Command frame checksum: XOR of the command byte and both argument bytes.
   function automatic logic [7:0] cmd_chk(input logic [7:0] code, input logic [15:0] arg);
      return code ^ arg[15:8] ^ arg[7:0];
   endfunction

endpackage

// File: rtl/uart_host_cmd_rsp_parser.sv
// Response frame parser: sync hunt, echo/length checks, sample assembly,
// running checksum and inter-byte timeout. Held cleared while not enabled.
module uart_rsp_parser
   import uart_host_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 20000,
   parameter int unsigned MAX_LEN        = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [7:0]  cmd_code,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        sample_valid,
   output logic [15:0] sample_data,
   output logic [15:0] sample_idx,
   output logic        fin,
   output logic [1:0]  err
);

   localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   rx_state_t     state, state_n;
   logic [TW-1:0] tmo_cnt;
   logic [7:0]    chk, len_hi, d_hi;
   logic [15:0]   remain, idx_next, len_full;
   logic          mis, over, tmo_hit, len_over;

   assign len_full = {len_hi, rx_data};
   assign len_over = {1'b0, len_full} > 17'(MAX_LEN);
   assign tmo_hit  = enable && !rx_valid && (tmo_cnt == TMO_LAST);

   // Parser state register.
   always_ff @(posedge clk) begin
      if (rst) state <= RX_HDR;
      else     state <= state_n;
   end

   // Next-state: advance one field per received byte; timeout or disable returns to sync hunt.
   always_comb begin
      state_n = state;
      if (!enable || tmo_hit) begin
         state_n = RX_HDR;
      end else if (rx_valid) begin
         case (state)
            RX_HDR:   if (rx_data == SYNC_RSP) state_n = RX_CMD;
            RX_CMD:   state_n = RX_LEN_H;
            RX_LEN_H: state_n = RX_LEN_L;
            RX_LEN_L: state_n = (len_full == 16'd0) ? RX_CHK : RX_D_H;
            RX_D_H:   state_n = RX_D_L;
            RX_D_L:   state_n = (remain == 16'd1) ? RX_CHK : RX_D_H;
            RX_CHK:   state_n = RX_HDR;
            default:  state_n = RX_HDR;
         endcase
      end
   end

   // Field capture, checksum accumulation, sample strobes and completion status.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         tmo_cnt      <= '0;
         chk          <= '0;
         len_hi       <= '0;
         d_hi         <= '0;
         remain       <= '0;
         idx_next     <= '0;
         mis          <= 1'b0;
         over         <= 1'b0;
         sample_valid <= 1'b0;
         sample_data  <= '0;
         sample_idx   <= '0;
         fin          <= 1'b0;
         err          <= ERR_OK;
      end else begin
         sample_valid <= 1'b0;
         fin          <= 1'b0;
         tmo_cnt      <= rx_valid ? '0 : tmo_cnt + 1'b1;
         if (tmo_hit) begin
            fin <= 1'b1;
            err <= ERR_TMO;
         end else if (rx_valid) begin
            case (state)
               RX_HDR: begin
                  chk  <= '0;
                  mis  <= 1'b0;
                  over <= 1'b0;
               end
               RX_CMD: begin
                  chk <= chk ^ rx_data;
                  mis <= (rx_data != cmd_code);
               end
               RX_LEN_H: begin
                  chk    <= chk ^ rx_data;
                  len_hi <= rx_data;
               end
               RX_LEN_L: begin
                  chk    <= chk ^ rx_data;
                  remain <= len_full;
                  if (len_over) begin
                     over <= 1'b1;
                     mis  <= 1'b1;
                  end
               end
               RX_D_H: begin
                  chk  <= chk ^ rx_data;
                  d_hi <= rx_data;
               end
               RX_D_L: begin
                  chk    <= chk ^ rx_data;
                  remain <= remain - 16'd1;
                  if (!over) begin
                     sample_valid <= 1'b1;
                     sample_data  <= {d_hi, rx_data};
                     sample_idx   <= idx_next;
                     idx_next     <= idx_next + 16'd1;
                  end
               end
               RX_CHK: begin
                  fin <= 1'b1;
                  if (mis)                 err <= ERR_MIS;
                  else if (chk != rx_data) err <= ERR_CHK;
                  else                     err <= ERR_OK;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/uart_host_cmd.sv
// Host-side UART command initiator: sends a 5-byte command frame through
// uart_tx, then hands reception to uart_rsp_parser and reports completion.
module uart_host_cmd
   import uart_host_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 20000,
   parameter int unsigned MAX_LEN        = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_start,
   input  logic [7:0]  cmd_code,
   input  logic [15:0] cmd_arg,
   output logic        cmd_busy,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        sample_valid,
   output logic [15:0] sample_data,
   output logic [15:0] sample_idx,
   output logic        rsp_done,
   output logic [1:0]  rsp_err
);

   host_state_t state, state_n;
   logic [7:0]  code_q;
   logic [15:0] arg_q;
   logic [2:0]  byte_cnt;
   logic [7:0]  frame_byte;
   logic        p_en, p_fin;
   logic [1:0]  p_err;

   uart_rsp_parser #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .MAX_LEN       (MAX_LEN)
   ) u_parser (
      .clk         (clk),
      .rst         (rst),
      .enable      (p_en),
      .cmd_code    (code_q),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .sample_valid(sample_valid),
      .sample_data (sample_data),
      .sample_idx  (sample_idx),
      .fin         (p_fin),
      .err         (p_err)
   );

   // Command frame byte selected by the TX byte counter.
   always_comb begin
      case (byte_cnt)
         3'd0:    frame_byte = SYNC_CMD;
         3'd1:    frame_byte = code_q;
         3'd2:    frame_byte = arg_q[15:8];
         3'd3:    frame_byte = arg_q[7:0];
         default: frame_byte = cmd_chk(code_q, arg_q);
      endcase
   end

   // Host state register.
   always_ff @(posedge clk) begin
      if (rst) state <= H_IDLE;
      else     state <= state_n;
   end

   // Next-state and strobes; outputs decode from state so reset drops them immediately.
   always_comb begin
      state_n  = state;
      tx_start = 1'b0;
      tx_data  = '0;
      cmd_busy = (state != H_IDLE) && (state != H_DONE);
      rsp_done = (state == H_DONE);
      p_en     = (state == H_RX);
      case (state)
         H_IDLE:    if (cmd_start) state_n = H_TX_LOAD;
         H_TX_LOAD: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               tx_data  = frame_byte;
               state_n  = H_TX_GAP;
            end
         end
         H_TX_GAP:  state_n = H_TX_WAIT;
         H_TX_WAIT: if (!tx_busy) state_n = (byte_cnt == 3'd4) ? H_RX : H_TX_LOAD;
         H_RX:      if (p_fin) state_n = H_DONE;
         H_DONE:    state_n = H_IDLE;
         default:   state_n = H_IDLE;
      endcase
   end

   // Command latch, TX byte counter and held completion status.
   always_ff @(posedge clk) begin
      if (rst) begin
         code_q   <= '0;
         arg_q    <= '0;
         byte_cnt <= '0;
         rsp_err  <= ERR_OK;
      end else begin
         if (state == H_IDLE && cmd_start) begin
            code_q   <= cmd_code;
            arg_q    <= cmd_arg;
            byte_cnt <= '0;
         end
         if (state == H_TX_WAIT && !tx_busy && byte_cnt != 3'd4)
            byte_cnt <= byte_cnt + 3'd1;
         if (state == H_RX && p_fin)
            rsp_err <= p_err;
      end
   end

endmodule

// File: tb/tb_uart_host_cmd.sv
// Self-checking bench for uart_host_cmd: behavioural UART tx responder,
// frame-level response model and directed plus randomized transactions.
module tb_uart_host_cmd;

   localparam int unsigned TMO  = 300;
   localparam int unsigned MAXL = 8;

   logic        clk = 1'b0;
   logic        rst, cmd_start, tx_busy, rx_valid;
   logic [7:0]  cmd_code, rx_data, tx_data;
   logic [15:0] cmd_arg, sample_data, sample_idx;
   logic        cmd_busy, tx_start, sample_valid, rsp_done;
   logic [1:0]  rsp_err;

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   int unsigned last_rx_cyc = 0;
   int          done_cnt = 0;
   logic [1:0]  done_err;
   logic        done_busy;
   int unsigned done_cyc = 0;
   logic [7:0]  txq[$];
   logic [15:0] sq[$];
   logic [15:0] siq[$];

   always #5 clk = ~clk;

   uart_host_cmd #(
      .TIMEOUT_CYCLES(TMO),
      .MAX_LEN       (MAXL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_start   (cmd_start),
      .cmd_code    (cmd_code),
      .cmd_arg     (cmd_arg),
      .cmd_busy    (cmd_busy),
      .tx_busy     (tx_busy),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .sample_valid(sample_valid),
      .sample_data (sample_data),
      .sample_idx  (sample_idx),
      .rsp_done    (rsp_done),
      .rsp_err     (rsp_err)
   );

   // cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // uart_tx stand-in: captures each strobed byte, then stays busy a few cycles
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            txq.push_back(tx_data);
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat ($urandom_range(2, 5)) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // response-side monitor
   initial forever begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
         sq.push_back(sample_data);
         siq.push_back(sample_idx);
      end
      if (rsp_done === 1'b1) begin
         done_cnt++;
         done_err  = rsp_err;
         done_busy = cmd_busy;
         done_cyc  = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put_rx(input logic [7:0] b, input int unsigned gap);
      repeat (gap) @(posedge clk);
      #1 rx_valid = 1'b1;
      rx_data = b;
      @(posedge clk);
      #1 rx_valid = 1'b0;
      last_rx_cyc = cyc;
   endtask

   task automatic pulse_start(input logic [7:0] code, input logic [15:0] arg);
      @(posedge clk);
      #1 cmd_code = code;
      cmd_arg   = arg;
      cmd_start = 1'b1;
      @(posedge clk);
      #1 cmd_start = 1'b0;
      cmd_code = 8'($urandom);
      cmd_arg  = 16'($urandom);
   endtask

   task automatic wait_tx(input string tag, input int n);
      for (int k = 0; k < 3000 && txq.size() < n; k++) @(posedge clk);
      if (txq.size() < n) begin
         checks++;
         errors++;
         $error("FAIL %s.tx_wait: observed %0d bytes expected %0d", tag, txq.size(), n);
      end
   endtask

   // One full transaction: command, frame-level response model, drive and compare.
   task automatic run_txn(input string tag, input logic [7:0] code, input logic [15:0] arg,
                          input logic [7:0] echo, input int unsigned len, input bit corrupt,
                          input bit trunc, input bit garbage, input bit use_seq,
                          input logic [15:0] seq_base);
      logic [7:0]  frame[$];
      logic [7:0]  exp_tx[5];
      logic [15:0] samp[$];
      logic [15:0] exp_s[$];
      logic [7:0]  x;
      logic [1:0]  exp_err;
      int          base_done;
      bit          in_win;
      int unsigned dly;

      for (int i = 0; i < int'(len); i++)
         samp.push_back(use_seq ? seq_base + 16'(i) : 16'($urandom));
      frame = {8'h5A, echo, 8'(len >> 8), 8'(len)};
      foreach (samp[i]) begin
         frame.push_back(samp[i][15:8]);
         frame.push_back(samp[i][7:0]);
      end
      x = 8'h00;
      for (int i = 1; i < frame.size(); i++) x ^= frame[i];
      frame.push_back(corrupt ? (x ^ 8'h01) : x);
      if (trunc) frame = frame[0:3];
      if (trunc)                          exp_err = 2'b10;
      else if (echo != code || len > MAXL) exp_err = 2'b11;
      else if (corrupt)                   exp_err = 2'b01;
      else                                exp_err = 2'b00;
      if (!trunc && len <= MAXL) exp_s = samp;
      exp_tx[0] = 8'hA5;
      exp_tx[1] = code;
      exp_tx[2] = arg[15:8];
      exp_tx[3] = arg[7:0];
      exp_tx[4] = code ^ arg[15:8] ^ arg[7:0];

      txq.delete();
      sq.delete();
      siq.delete();
      base_done = done_cnt;
      pulse_start(code, arg);
      check({tag, ".busy"}, 32'(cmd_busy), 32'd1);
      // second request while busy must be dropped
      cmd_start = 1'b1;
      @(posedge clk);
      #1 cmd_start = 1'b0;
      // bytes arriving during the TX phase must be dropped
      put_rx(8'h5A, 0);
      put_rx(code, 1);

      wait_tx(tag, 5);
      for (int i = 0; i < 5; i++)
         check($sformatf("%s.tx%0d", tag, i),
               (i < txq.size()) ? 32'(txq[i]) : 32'hxxxx_xxxx, 32'(exp_tx[i]));
      repeat (12) @(posedge clk);
      #1;
      if (garbage) begin
         put_rx(8'h00, 1);
         put_rx(8'hFF, 1);
      end
      foreach (frame[i]) put_rx(frame[i], $urandom_range(0, 4));

      for (int k = 0; k < int'(TMO) + 200 && done_cnt == base_done; k++) @(posedge clk);
      if (done_cnt == base_done) begin
         checks++;
         errors++;
         $error("FAIL %s.done_wait: observed no rsp_done expected one", tag);
      end
      repeat (3) @(posedge clk);
      #1;
      check({tag, ".done_cnt"}, 32'(done_cnt), 32'(base_done + 1));
      check({tag, ".err"}, 32'(done_err), 32'(exp_err));
      check({tag, ".busy_at_done"}, 32'(done_busy), 32'd0);
      check({tag, ".err_hold"}, 32'(rsp_err), 32'(exp_err));
      check({tag, ".nsamp"}, 32'(sq.size()), 32'(exp_s.size()));
      for (int i = 0; i < exp_s.size() && i < sq.size(); i++) begin
         check($sformatf("%s.s%0d", tag, i), 32'(sq[i]), 32'(exp_s[i]));
         check($sformatf("%s.idx%0d", tag, i), 32'(siq[i]), 32'(i));
      end
      if (trunc) begin
         dly    = done_cyc - last_rx_cyc;
         in_win = (dly >= TMO) && (dly <= TMO + 3);
         if (!in_win) $display("%s timeout delay observed %0d cycles, window %0d..%0d", tag, dly, TMO, TMO + 3);
         check({tag, ".tmo_delay"}, 32'(in_win), 32'd1);
      end
   endtask

   initial begin
      int          base_done;
      logic [7:0]  rc;
      logic [7:0]  re;
      int unsigned rl;

      rst       = 1'b1;
      cmd_start = 1'b0;
      cmd_code  = 8'h00;
      cmd_arg   = 16'h0000;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst.tx_start", 32'(tx_start), 32'd0);
      check("rst.tx_data", 32'(tx_data), 32'd0);
      check("rst.cmd_busy", 32'(cmd_busy), 32'd0);
      check("rst.rsp_done", 32'(rsp_done), 32'd0);
      check("rst.rsp_err", 32'(rsp_err), 32'd0);
      check("rst.sample_valid", 32'(sample_valid), 32'd0);
      check("rst.sample_idx", 32'(sample_idx), 32'd0);
      rst = 1'b0;

      // 1 good STREAM response, samples 1000..1002
      run_txn("t1", 8'h04, 16'h0000, 8'h04, 3, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1000);
      // 2 corrupted checksum
      run_txn("t2", 8'h04, 16'h0000, 8'h04, 3, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1000);
      // 3 response stops after len_lo
      run_txn("t3", 8'h04, 16'h0000, 8'h04, 3, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      // 4 garbage before sync, echo mismatch
      run_txn("t4", 8'h04, 16'h0000, 8'h05, 3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      // 5 zero-length response
      run_txn("t5", 8'h04, 16'h0000, 8'h04, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      // length just above the limit: consumed, no samples
      run_txn("t5b", 8'h04, 16'h1234, 8'h04, MAXL + 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

      // 6 reset during TX byte 2, then a full new command
      txq.delete();
      base_done = done_cnt;
      pulse_start(8'h04, 16'hBEEF);
      for (int k = 0; k < 2000 && txq.size() < 3; k++) @(posedge clk);
      check("t6.bytes_before_rst", 32'(txq.size()), 32'd3);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6.tx_start", 32'(tx_start), 32'd0);
      check("t6.cmd_busy", 32'(cmd_busy), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 50 && tx_busy; k++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      check("t6.no_done", 32'(done_cnt), 32'(base_done));
      run_txn("t6n", 8'h04, 16'hBEEF, 8'h04, 2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

      // randomized transactions
      for (int n = 0; n < 8; n++) begin
         rc = 8'($urandom);
         rl = $urandom_range(0, MAXL + 3);
         re = ($urandom_range(0, 3) == 0) ? (rc ^ 8'(1 << $urandom_range(0, 7))) : rc;
         run_txn($sformatf("r%0d", n), rc, 16'($urandom), re, rl,
                 ($urandom_range(0, 3) == 0), 1'b0, 1'b0, 1'b0, 16'h0000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
